// File: rtl/mips_run_ctrl_pkg.sv
// mips_run_ctrl_pkg
//   Shared definitions for the MIPS run controller: FSM state encoding,
//   run-mode constants and the reset-stretch counter width helper.
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  // Width needed to hold a stretch count of 0..rst_cycles.
  function automatic int unsigned stretch_w(input int unsigned rst_cycles);
    return $clog2(rst_cycles + 1);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if
//   Control/status bundle between the board-level run logic and the
//   run controller.
//   master : drives i_mode, i_start, i_step, i_stop, i_cpu_halt;
//            observes o_cpu_reset, o_cpu_enable, o_cycle_count, o_state, o_done
//   slave  : the controller side (mirror directions)
interface mips_run_ctrl_if #(
  parameter int unsigned LEN = 32
);
  logic           i_mode;
  logic           i_start;
  logic           i_step;
  logic           i_stop;
  logic           i_cpu_halt;
  logic           o_cpu_reset;
  logic           o_cpu_enable;
  logic [LEN-1:0] o_cycle_count;
  logic [2:0]     o_state;
  logic           o_done;

  modport master (
    output i_mode, i_start, i_step, i_stop, i_cpu_halt,
    input  o_cpu_reset, o_cpu_enable, o_cycle_count, o_state, o_done
  );

  modport slave (
    input  i_mode, i_start, i_step, i_stop, i_cpu_halt,
    output o_cpu_reset, o_cpu_enable, o_cycle_count, o_state, o_done
  );
endinterface

// File: rtl/mips_reset_sync.sv
// mips_reset_sync
//   Asynchronous-assert, synchronous-release reset conditioner with a
//   RST_CYCLES stretch. rst_done rises so that the FSM leaves RST_HOLD on
//   the RST_CYCLES-th clock edge after reset release (edge 0 being the
//   first edge after release).
//   clk      in  system clock
//   reset    in  asynchronous active-low reset
//   restart  in  synchronous request to replay the release sequence
//   rst_done out level, high once the stretch has elapsed
module mips_reset_sync
  import mips_run_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic rst_done
);

  localparam int unsigned CW  = stretch_w(RST_CYCLES);
  // The two synchronizer edges are part of the stretch, so the counter
  // only covers the remainder.
  localparam int unsigned THR = (RST_CYCLES >= 2) ? RST_CYCLES - 2 : 0;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else if (restart) begin
      // Land in the same state as just after edge 0 of a power-up release,
      // so a restart holds the CPU for exactly RST_CYCLES cycles too.
      s1  <= 1'b1;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= 1'b1;
      s2 <= s1;
      if (s2 && (cnt < CW'(THR)))
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    rst_done = 1'b0;
    if (RST_CYCLES == 1)
      rst_done = s1;
    else
      rst_done = s2 && (cnt >= CW'(THR));
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl
//   Run controller for the MIPS pipeline top: conditions reset, gates the
//   pipeline clock-enable under continuous-run or single-step control,
//   counts enabled cycles (saturating) and flags completion on CPU halt.
//   clk    in  system clock
//   reset  in  asynchronous active-low reset
//   bus    slave side of mips_run_ctrl_if
//          i_mode/i_start/i_step/i_stop/i_cpu_halt : run control inputs
//          o_cpu_reset/o_cpu_enable/o_done         : decoded from state reg
//          o_cycle_count                           : enabled-cycle count
//          o_state                                 : FSM state for debug
module mips_run_ctrl
  import mips_run_ctrl_pkg::*;
#(
  parameter int unsigned LEN        = 32,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  mips_run_ctrl_if.slave   bus
);

  state_t         state;
  state_t         state_nx;
  logic           restart;
  logic           rst_done;
  logic           enable;
  logic [LEN-1:0] cycle_cnt;

  mips_reset_sync #(
    .RST_CYCLES(RST_CYCLES)
  ) u_reset_sync (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .rst_done (rst_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= ST_RST_HOLD;
    else
      state <= state_nx;
  end

  // Priority: halt > stop > start/step. Halt only matters while enabled.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    case (state)
      ST_RST_HOLD: begin
        if (rst_done)
          state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.i_stop)
          state_nx = ST_IDLE;
        else if (bus.i_start)
          state_nx = (bus.i_mode == MODE_STEP) ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_cpu_halt)
          state_nx = ST_DONE;
        else if (bus.i_stop)
          state_nx = ST_IDLE;
      end
      ST_STEP_WAIT: begin
        if (bus.i_stop)
          state_nx = ST_IDLE;
        else if (bus.i_step)
          state_nx = ST_STEP;
      end
      ST_STEP: begin
        if (bus.i_cpu_halt)
          state_nx = ST_DONE;
        else
          state_nx = ST_STEP_WAIT;
      end
      ST_DONE: begin
        if (bus.i_start) begin
          state_nx = ST_RST_HOLD;
          restart  = 1'b1;
        end
      end
      default: state_nx = ST_RST_HOLD;
    endcase
  end

  always_comb begin
    enable = (state == ST_RUN) || (state == ST_STEP);
  end

  // Cleared on the restart edge itself so the count reads 0 as soon as the
  // CPU is back in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cycle_cnt <= '0;
    else if ((state == ST_RST_HOLD) || restart)
      cycle_cnt <= '0;
    else if (enable && (cycle_cnt != '1))
      cycle_cnt <= cycle_cnt + LEN'(1);
  end

  always_comb begin
    bus.o_cpu_reset   = (state == ST_RST_HOLD);
    bus.o_cpu_enable  = enable;
    bus.o_done        = (state == ST_DONE);
    bus.o_state       = state;
    bus.o_cycle_count = cycle_cnt;
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
module tb_mips_run_ctrl;
  import mips_run_ctrl_pkg::*;

  logic clk;
  logic reset;
  logic mode, start, step, stop, halt;

  int total = 0;
  int bad   = 0;

  mips_run_ctrl_if #(.LEN(32)) ifa ();
  mips_run_ctrl_if #(.LEN(4))  ifb ();

  assign ifa.i_mode = mode;  assign ifb.i_mode = mode;
  assign ifa.i_start = start; assign ifb.i_start = start;
  assign ifa.i_step = step;  assign ifb.i_step = step;
  assign ifa.i_stop = stop;  assign ifb.i_stop = stop;
  assign ifa.i_cpu_halt = halt; assign ifb.i_cpu_halt = halt;

  mips_run_ctrl #(.LEN(32), .RST_CYCLES(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mips_run_ctrl #(.LEN(4), .RST_CYCLES(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mode, start, step, stop, halt;
    state_t      st;
    logic        en, rst, done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic m, input logic sa, input logic sp,
                     input logic so, input logic h, input state_t st, input logic en,
                     input logic rs, input logic dn, input int unsigned cnt);
    vec_t v;
    v.name = nm; v.mode = m; v.start = sa; v.step = sp; v.stop = so; v.halt = h;
    v.st = st; v.en = en; v.rst = rs; v.done = dn; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode = 1'b0; start = 1'b0; step = 1'b0; stop = 1'b0; halt = 1'b0;
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b0;

    // ---- fill vector table (DUT a, LEN=32, RST_CYCLES=4), starting in IDLE ----
    // continuous run, halt on the 10th enabled cycle
    add("run_start", 0, 1, 0, 0, 0, ST_RUN, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add("run", 0, 0, 0, 0, 0, ST_RUN, 1, 0, 0, k);
    add("run_halt",  0, 0, 0, 0, 1, ST_DONE, 0, 0, 1, 10);
    add("done_hold", 0, 0, 1, 1, 0, ST_DONE, 0, 0, 1, 10);
    // restart from DONE: 4 cycles of cpu reset, count cleared
    add("restart",      0, 1, 0, 0, 0, ST_RST_HOLD, 0, 1, 0, 0);
    add("restart_hold", 0, 1, 0, 0, 0, ST_RST_HOLD, 0, 1, 0, 0);
    add("restart_hold", 0, 0, 0, 0, 0, ST_RST_HOLD, 0, 1, 0, 0);
    add("restart_hold", 0, 0, 0, 0, 0, ST_RST_HOLD, 0, 1, 0, 0);
    add("restart_idle", 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0, 0);
    add("idle_stop_start", 0, 1, 0, 1, 0, ST_IDLE, 0, 0, 0, 0);
    // single step, three steps spaced 3 cycles; first step held 2 cycles
    add("step_start", 1, 1, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 0);
    add("step1",      0, 0, 1, 0, 0, ST_STEP,      1, 0, 0, 0);
    add("step1_held", 0, 0, 1, 0, 0, ST_STEP_WAIT, 0, 0, 0, 1);
    add("sw",         0, 0, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 1);
    add("step2",      0, 0, 1, 0, 0, ST_STEP,      1, 0, 0, 1);
    add("sw",         0, 0, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 2);
    add("sw",         0, 0, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 2);
    add("step3",      0, 0, 1, 0, 0, ST_STEP,      1, 0, 0, 2);
    add("sw",         0, 0, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 3);
    add("sw_halt_ign",  0, 0, 0, 0, 1, ST_STEP_WAIT, 0, 0, 0, 3);
    add("sw_start_ign", 0, 1, 0, 0, 0, ST_STEP_WAIT, 0, 0, 0, 3);
    add("sw_stop_step", 0, 0, 1, 1, 0, ST_IDLE,      0, 0, 0, 3);
    // pause/resume: 5 enabled cycles then stop, hold, resume, stop+halt
    add("resume_run", 0, 1, 0, 0, 0, ST_RUN, 1, 0, 0, 3);
    for (int k = 4; k <= 7; k++) add("run2", 0, 0, 0, 0, 0, ST_RUN, 1, 0, 0, k);
    add("pause_stop", 0, 0, 0, 1, 0, ST_IDLE, 0, 0, 0, 8);
    add("pause_hold", 0, 0, 1, 0, 0, ST_IDLE, 0, 0, 0, 8);
    add("pause_hold", 0, 0, 0, 0, 1, ST_IDLE, 0, 0, 0, 8);
    add("pause_hold", 0, 0, 0, 1, 0, ST_IDLE, 0, 0, 0, 8);
    add("pause_hold", 0, 0, 0, 0, 0, ST_IDLE, 0, 0, 0, 8);
    add("resume2",    0, 1, 0, 0, 0, ST_RUN,  1, 0, 0, 8);
    add("run3",       0, 0, 0, 0, 0, ST_RUN,  1, 0, 0, 9);
    add("stop_halt",  0, 0, 0, 1, 1, ST_DONE, 0, 0, 1, 10);

    // ---- reset state ----
    #1;
    chk("rst_state", 64'(ifa.o_state), 64'(ST_RST_HOLD));
    chk("rst_cpu_reset", 64'(ifa.o_cpu_reset), 64'd1);
    chk("rst_enable", 64'(ifa.o_cpu_enable), 64'd0);
    chk("rst_count", 64'(ifa.o_cycle_count), 64'd0);
    chk("rst_done", 64'(ifa.o_done), 64'd0);
    chk("rst_count_b", 64'(ifb.o_cycle_count), 64'd0);

    // ---- reset release: cpu reset high for exactly RST_CYCLES edges ----
    #16 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ifa.o_cpu_reset) n++;
      else break;
    end
    chk("rel_reset_edges", 64'(n), 64'd4);
    chk("rel_state", 64'(ifa.o_state), 64'(ST_IDLE));
    chk("rel_enable", 64'(ifa.o_cpu_enable), 64'd0);
    chk("rel_count", 64'(ifa.o_cycle_count), 64'd0);

    // ---- table-driven vectors ----
    foreach (tbl[i]) begin
      mode = tbl[i].mode; start = tbl[i].start; step = tbl[i].step;
      stop = tbl[i].stop; halt = tbl[i].halt;
      tick();
      chk($sformatf("%s_%0d_state", tbl[i].name, i), 64'(ifa.o_state), 64'(tbl[i].st));
      chk($sformatf("%s_%0d_en", tbl[i].name, i), 64'(ifa.o_cpu_enable), 64'(tbl[i].en));
      chk($sformatf("%s_%0d_rst", tbl[i].name, i), 64'(ifa.o_cpu_reset), 64'(tbl[i].rst));
      chk($sformatf("%s_%0d_done", tbl[i].name, i), 64'(ifa.o_done), 64'(tbl[i].done));
      chk($sformatf("%s_%0d_cnt", tbl[i].name, i), 64'(ifa.o_cycle_count), 64'(tbl[i].cnt));
    end
    idle_inputs();

    // ---- mid-run asynchronous abort ----
    start = 1'b1; tick(); start = 1'b0;
    chk("abort_restart_state", 64'(ifa.o_state), 64'(ST_RST_HOLD));
    for (int i = 0; i < 10 && ifa.o_state != ST_IDLE; i++) tick();
    chk("abort_idle_reached", 64'(ifa.o_state), 64'(ST_IDLE));
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre_cnt", 64'(ifa.o_cycle_count), 64'd3);
    chk("abort_pre_state", 64'(ifa.o_state), 64'(ST_RUN));
    #3 reset = 1'b0;
    #1;
    chk("abort_state", 64'(ifa.o_state), 64'(ST_RST_HOLD));
    chk("abort_cpu_reset", 64'(ifa.o_cpu_reset), 64'd1);
    chk("abort_enable", 64'(ifa.o_cpu_enable), 64'd0);
    chk("abort_count", 64'(ifa.o_cycle_count), 64'd0);
    chk("abort_done", 64'(ifa.o_done), 64'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 20 && ifa.o_state != ST_IDLE; i++) tick();
    chk("abort_rel_idle", 64'(ifa.o_state), 64'(ST_IDLE));

    // ---- saturation and restart on LEN=4 instance ----
    chk("sat_idle_b", 64'(ifb.o_state), 64'(ST_IDLE));
    start = 1'b1; tick(); start = 1'b0;
    chk("sat_run_b", 64'(ifb.o_state), 64'(ST_RUN));
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", k), 64'(ifb.o_cycle_count), 64'((k < 15) ? k : 15));
    end
    chk("sat_still_run_b", 64'(ifb.o_state), 64'(ST_RUN));
    halt = 1'b1; tick(); halt = 1'b0;
    chk("sat_done_b", 64'(ifb.o_done), 64'd1);
    chk("sat_done_cnt_b", 64'(ifb.o_cycle_count), 64'd15);
    start = 1'b1; tick(); start = 1'b0;
    chk("sat_restart_cnt_b", 64'(ifb.o_cycle_count), 64'd0);
    n = ifb.o_cpu_reset ? 1 : 0;
    for (int i = 0; i < 20 && ifb.o_cpu_reset; i++) begin
      tick();
      if (ifb.o_cpu_reset) n++;
    end
    chk("sat_restart_rst_cycles_b", 64'(n), 64'd4);
    chk("sat_restart_idle_b", 64'(ifb.o_state), 64'(ST_IDLE));
    chk("sat_restart_cnt_idle_b", 64'(ifb.o_cycle_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
